// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// plus the helper that decides which opcodes take the iterative path.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    NEG_B = 4'd2,
    MUL   = 4'd3,
    DIV   = 4'd4,
    REM   = 4'd5,
    AND   = 4'd6,
    OR    = 4'd7,
    A_N   = 4'd8,
    XOR   = 4'd9,
    SHL   = 4'd10,
    SHR   = 4'd11,
    SRA   = 4'd12
  } alu_seq_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_seq_state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == MUL) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/alu_seq_iter_core.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one step
// per cycle. Outputs are the {acc, quot} values produced by the current step.
module alu_seq_iter_core
  import alu_seq_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [LENGTH-1:0] a_mag,
  input  logic [LENGTH-1:0] b_mag,
  output logic [LENGTH-1:0] acc_nxt,
  output logic [LENGTH-1:0] quot_nxt
);

  logic [LENGTH-1:0] acc_q, acc_d;
  logic [LENGTH-1:0] quot_q, quot_d;
  logic [LENGTH-1:0] b_q, b_d;
  logic              is_div_q, is_div_d;
  logic [LENGTH:0]   sum_w;
  logic [LENGTH:0]   shifted_w;
  logic [LENGTH:0]   diff_w;

  always_comb begin
    sum_w     = {1'b0, acc_q} + ({1'b0, b_q} & {(LENGTH+1){quot_q[0]}});
    shifted_w = {acc_q, quot_q[LENGTH-1]};
    diff_w    = shifted_w - {1'b0, b_q};
    // acc < divisor is invariant, so bit LENGTH of diff_w is a clean borrow.
    if (is_div_q) begin
      if (!diff_w[LENGTH]) begin
        acc_nxt  = diff_w[LENGTH-1:0];
        quot_nxt = {quot_q[LENGTH-2:0], 1'b1};
      end else begin
        acc_nxt  = shifted_w[LENGTH-1:0];
        quot_nxt = {quot_q[LENGTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt  = sum_w[LENGTH:1];
      quot_nxt = {sum_w[0], quot_q[LENGTH-1:1]};
    end
  end

  always_comb begin
    acc_d    = acc_q;
    quot_d   = quot_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    if (load) begin
      acc_d    = '0;
      quot_d   = a_mag;
      b_d      = b_mag;
      is_div_d = is_div;
    end else if (step) begin
      acc_d  = acc_nxt;
      quot_d = quot_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      quot_q   <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      quot_q   <= quot_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed
// MUL/DIV/REM behind one valid/ready front end; results held until accepted.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int LENGTH      = 8,
  parameter int SHAMT_W     = $clog2(LENGTH),
  parameter bit CHECK_PARAM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] A,
  input  logic [LENGTH-1:0] B,
  input  logic [3:0]        ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] Result,
  output logic [LENGTH-1:0] Result_hi,
  output logic              carry_f,
  output logic              overflow_f,
  output logic              zero_f,
  output logic              div0_f,
  output logic              illegal_f
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  localparam logic [LENGTH-1:0] MIN_VAL = {1'b1, {(LENGTH-1){1'b0}}};

  if (CHECK_PARAM && ((LENGTH < 4) || ((LENGTH & (LENGTH - 1)) != 0))) begin : g_param_check
    $fatal(1, "alu_seq_muldiv: LENGTH must be a power of two and at least 4");
  end

  alu_seq_state_e     state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [3:0]         op_q, op_d;
  logic               neg_q, neg_d, a_neg_q, a_neg_d;
  logic               b_zero_q, b_zero_d, min_neg1_q, min_neg1_d;
  logic [LENGTH-1:0]  result_q, result_d, result_hi_q, result_hi_d;
  logic               carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic               div0_q, div0_d, illegal_q, illegal_d;

  logic [SHAMT_W-1:0] shamt;
  logic [LENGTH:0]    add_w, sub_w;
  logic [LENGTH-1:0]  sc_res;
  logic               sc_carry, sc_ovf, sc_illegal;

  always_comb begin
    shamt      = B[SHAMT_W-1:0];
    add_w      = {1'b0, A} + {1'b0, B};
    sub_w      = {1'b0, A} - {1'b0, B};
    sc_res     = '0;
    sc_carry   = 1'b0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
    case (ctrl)
      ADD: begin
        sc_res   = add_w[LENGTH-1:0];
        sc_carry = add_w[LENGTH];
        sc_ovf   = (A[LENGTH-1] == B[LENGTH-1]) && (add_w[LENGTH-1] != A[LENGTH-1]);
      end
      SUB: begin
        sc_res   = sub_w[LENGTH-1:0];
        sc_carry = sub_w[LENGTH];
        sc_ovf   = (A[LENGTH-1] != B[LENGTH-1]) && (sub_w[LENGTH-1] != A[LENGTH-1]);
      end
      NEG_B: begin
        sc_res = -B;
        sc_ovf = (B == MIN_VAL);
      end
      AND:           sc_res = A & B;
      OR:            sc_res = A | B;
      A_N:           sc_res = ~A;
      XOR:           sc_res = A ^ B;
      SHL:           sc_res = A << shamt;
      SHR:           sc_res = A >> shamt;
      SRA:           sc_res = $signed(A) >>> shamt;
      MUL, DIV, REM: sc_res = '0;
      default:       sc_illegal = 1'b1;
    endcase
  end

  logic [LENGTH-1:0] a_mag, b_mag, core_acc, core_quot;
  logic              core_load, core_step;

  assign a_mag = A[LENGTH-1] ? -A : A;
  assign b_mag = B[LENGTH-1] ? -B : B;

  alu_seq_iter_core #(.LENGTH(LENGTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .step     (core_step),
    .is_div   (ctrl != MUL),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_nxt  (core_acc),
    .quot_nxt (core_quot)
  );

  logic [2*LENGTH-1:0] prod_mag, prod_s;
  logic [LENGTH-1:0]   quot_s, rem_s, mc_res, mc_hi;
  logic                mc_ovf, mc_div0;

  // Sign correction of the unsigned engine result; applied on the last step.
  always_comb begin
    prod_mag = {core_acc, core_quot};
    prod_s   = neg_q ? -prod_mag : prod_mag;
    quot_s   = neg_q ? -core_quot : core_quot;
    rem_s    = a_neg_q ? -core_acc : core_acc;
    mc_res   = rem_s;
    mc_hi    = '0;
    mc_ovf   = 1'b0;
    mc_div0  = 1'b0;
    case (op_q)
      MUL: begin
        mc_res = prod_s[LENGTH-1:0];
        mc_hi  = prod_s[2*LENGTH-1:LENGTH];
        mc_ovf = (mc_hi != {LENGTH{mc_res[LENGTH-1]}});
      end
      DIV: begin
        mc_res  = b_zero_q ? '1 : quot_s;
        mc_ovf  = min_neg1_q;
        mc_div0 = b_zero_q;
      end
      default: begin
        mc_ovf  = min_neg1_q;
        mc_div0 = b_zero_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    neg_d       = neg_q;
    a_neg_d     = a_neg_q;
    b_zero_d    = b_zero_q;
    min_neg1_d  = min_neg1_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    div0_d      = div0_q;
    illegal_d   = illegal_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_multicycle(ctrl)) begin
            state_d    = BUSY;
            count_d    = SHAMT_W'(LENGTH - 1);
            op_d       = ctrl;
            neg_d      = A[LENGTH-1] ^ B[LENGTH-1];
            a_neg_d    = A[LENGTH-1];
            b_zero_d   = (B == '0);
            min_neg1_d = (A == MIN_VAL) && (B == '1);
            core_load  = 1'b1;
          end else begin
            state_d     = DONE;
            result_d    = sc_res;
            result_hi_d = '0;
            carry_d     = sc_carry;
            ovf_d       = sc_ovf;
            zero_d      = (sc_res == '0);
            div0_d      = 1'b0;
            illegal_d   = sc_illegal;
          end
        end
      end
      BUSY: begin
        core_step = 1'b1;
        count_d   = count_q - SHAMT_W'(1);
        if (count_q == '0) begin
          state_d     = DONE;
          result_d    = mc_res;
          result_hi_d = mc_hi;
          carry_d     = 1'b0;
          ovf_d       = mc_ovf;
          zero_d      = (mc_res == '0);
          div0_d      = mc_div0;
          illegal_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      b_zero_q    <= 1'b0;
      min_neg1_q  <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      a_neg_q     <= a_neg_d;
      b_zero_q    <= b_zero_d;
      min_neg1_q  <= min_neg1_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      div0_q      <= div0_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign Result     = result_q;
  assign Result_hi  = result_hi_q;
  assign carry_f    = carry_q;
  assign overflow_f = ovf_q;
  assign zero_f     = zero_q;
  assign div0_f     = div0_q;
  assign illegal_f  = illegal_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Bench for alu_seq_muldiv (LENGTH = 8): vector table, model-checked random
// ops, back-pressure hold and reset-abort sequences, one summary line.
module tb_alu_seq_muldiv;
  import alu_seq_pkg::*;

  localparam int W  = 8;
  localparam int EW = 2*W + 5;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result, result_hi;
  logic [3:0]   ctrl;
  logic         carry_f, overflow_f, zero_f, div0_f, illegal_f;

  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  alu_seq_muldiv #(.LENGTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a),
    .B          (b),
    .ctrl       (ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (result),
    .Result_hi  (result_hi),
    .carry_f    (carry_f),
    .overflow_f (overflow_f),
    .zero_f     (zero_f),
    .div0_f     (div0_f),
    .illegal_f  (illegal_f)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [4:0]   flags;  // {carry, overflow, zero, div0, illegal}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] res, input logic [W-1:0] hi, input logic [4:0] fl);
    vec_t v;
    v.op = op; v.a = av; v.b = bv; v.res = res; v.hi = hi; v.flags = fl;
    return v;
  endfunction

  function automatic logic [EW-1:0] actual();
    return {result_hi, result, carry_f, overflow_f, zero_f, div0_f, illegal_f};
  endfunction

  // reference model for the randomised ops
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic [W-1:0]   r, h;
    logic           c, o, d;
    int             xi, yi;
    xi = $signed(x);
    yi = $signed(y);
    r = '0; h = '0; c = 1'b0; o = 1'b0; d = 1'b0; s = '0; p = '0;
    case (op)
      ADD: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; c = s[W];
        o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      SUB: begin
        s = {1'b0, x} - {1'b0, y};
        r = s[W-1:0]; c = s[W];
        o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      MUL: begin
        p = (2*W)'(xi * yi);
        r = p[W-1:0]; h = p[2*W-1:W];
        o = (h != {W{r[W-1]}});
      end
      default: begin
        if (y == '0) begin
          r = (op == DIV) ? '1 : x;
          d = 1'b1;
        end else if ((x == 8'h80) && (y == 8'hFF)) begin
          r = (op == DIV) ? 8'h80 : 8'h00;
          o = 1'b1;
        end else begin
          r = (op == DIV) ? W'(xi / yi) : W'(xi % yi);
        end
      end
    endcase
    return {h, r, c, o, (r == '0), d, 1'b0};
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic wait_out(output int waited);
    waited = 0;
    while (!out_valid && waited < 4*W) begin
      @(posedge clk); #1;
      waited++;
    end
  endtask

  // driver: one op through the full handshake, latency and result checked
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [EW-1:0] expv);
    int waited;
    logic [EW-1:0] e;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; ctrl = op; a = av; b = bv;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); ctrl = 4'($urandom);
    wait_out(waited);
    check({name, "_latency"}, 32'(waited), is_multicycle(op) ? 32'(W) : 32'd0);
    e = exp_q.pop_front();
    check({name, "_result"}, 32'(actual()), 32'(e));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int   waited;
    int   seen;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    logic [EW-1:0] e;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ctrl = '0;

    vecs.push_back(mk(ADD,   8'h7F, 8'h01, 8'h80, 8'h00, 5'b01000));
    vecs.push_back(mk(ADD,   8'hFF, 8'h01, 8'h00, 8'h00, 5'b10100));
    vecs.push_back(mk(SUB,   8'h00, 8'h01, 8'hFF, 8'h00, 5'b10000));
    vecs.push_back(mk(SUB,   8'h80, 8'h01, 8'h7F, 8'h00, 5'b01000));
    vecs.push_back(mk(NEG_B, 8'h11, 8'h80, 8'h80, 8'h00, 5'b01000));
    vecs.push_back(mk(NEG_B, 8'h11, 8'h05, 8'hFB, 8'h00, 5'b00000));
    vecs.push_back(mk(AND,   8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000));
    vecs.push_back(mk(OR,    8'hF0, 8'h0F, 8'hFF, 8'h00, 5'b00000));
    vecs.push_back(mk(A_N,   8'hFF, 8'h12, 8'h00, 8'h00, 5'b00100));
    vecs.push_back(mk(XOR,   8'hAA, 8'hAA, 8'h00, 8'h00, 5'b00100));
    vecs.push_back(mk(SHL,   8'h81, 8'h09, 8'h02, 8'h00, 5'b00000));
    vecs.push_back(mk(SHR,   8'h80, 8'h03, 8'h10, 8'h00, 5'b00000));
    vecs.push_back(mk(SRA,   8'h80, 8'h03, 8'hF0, 8'h00, 5'b00000));
    vecs.push_back(mk(4'd13, 8'h12, 8'h34, 8'h00, 8'h00, 5'b00101));
    vecs.push_back(mk(MUL,   8'hFD, 8'h05, 8'hF1, 8'hFF, 5'b00000));
    vecs.push_back(mk(MUL,   8'h40, 8'h04, 8'h00, 8'h01, 5'b01100));
    vecs.push_back(mk(MUL,   8'h80, 8'h80, 8'h00, 8'h40, 5'b01100));
    vecs.push_back(mk(MUL,   8'h7F, 8'h7F, 8'h01, 8'h3F, 5'b01000));
    vecs.push_back(mk(DIV,   8'h80, 8'hFF, 8'h80, 8'h00, 5'b01000));
    vecs.push_back(mk(REM,   8'h80, 8'hFF, 8'h00, 8'h00, 5'b01100));
    vecs.push_back(mk(REM,   8'hF9, 8'h02, 8'hFF, 8'h00, 5'b00000));
    vecs.push_back(mk(DIV,   8'h2A, 8'h00, 8'hFF, 8'h00, 5'b00010));
    vecs.push_back(mk(REM,   8'h2A, 8'h00, 8'h2A, 8'h00, 5'b00010));
    vecs.push_back(mk(DIV,   8'h64, 8'hF9, 8'hF2, 8'h00, 5'b00000));
    vecs.push_back(mk(REM,   8'h64, 8'hF9, 8'h02, 8'h00, 5'b00000));

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({out_valid, actual()}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", {30'd0, out_valid, in_ready}, 32'd1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].hi, vecs[i].res, vecs[i].flags});

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       rop = ADD;
        1:       rop = SUB;
        2:       rop = MUL;
        3:       rop = DIV;
        default: rop = REM;
      endcase
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // back-pressure: held outputs, in_valid ignored while busy/done
    @(negedge clk);
    in_valid = 1'b1; ctrl = MUL; a = 8'hFD; b = 8'h05;
    exp_q.push_back({16'hFFF1, 5'b00000});
    @(posedge clk); #1;
    ctrl = ADD; a = 8'h01; b = 8'h01;
    wait_out(waited);
    check("hold_latency", 32'(waited), 32'(W));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_stable%0d", i), {14'd0, in_ready, out_valid, result_hi, result},
            {14'd0, 2'b01, 16'hFFF1});
    end
    e = exp_q.pop_front();
    check("hold_result", 32'(actual()), 32'(e));
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release", {30'd0, out_valid, in_ready}, 32'd1);

    // reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; ctrl = DIV; a = 8'h2A; b = 8'h03;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({out_valid, actual()}), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2*W; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_no_pending", 32'(seen), 32'd0);
    check("rst_ready_after", 32'(in_ready), 32'd1);
    run_op("post_rst_div", DIV, 8'h2A, 8'h03, {8'h00, 8'h0E, 5'b00000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
